// File: rtl/mastermind_timer_pkg.sv
// Shared timer definitions for the Mastermind turn timer and its display logic.
//  - timer_state_t : 2-bit FSM encoding (IDLE / RUN / DONE)
//  - DEF_CLK_HZ    : default system clock cycles per one-second tick
//  - DEF_TURN_SECS : default seconds allowed per turn
package mastermind_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } timer_state_t;

    localparam int DEF_CLK_HZ    = 50_000_000;
    localparam int DEF_TURN_SECS = 60;

endpackage

// File: rtl/sec_prescaler.sv
// Clock-to-seconds prescaler.
//  clk    in  system clock
//  resetn in  synchronous active-low reset
//  clr    in  force count back to 0 (beats en)
//  en     in  advance the count
//  tick   out registered one-cycle pulse on the edge the count wraps
//  wrap   out combinational: the coming edge is a wrap edge, lets the
//             owner update its own registers on the same edge as tick
module sec_prescaler
    import mastermind_timer_pkg::*;
#(
    parameter int CLK_HZ = DEF_CLK_HZ
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic tick,
    output logic wrap
);

    localparam int            CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt;

    assign wrap = en && !clr && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + CW'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/turn_countdown_timer.sv
// Per-turn countdown timer for the Mastermind game.
//  clk          in  system clock
//  resetn       in  synchronous active-low reset
//  next_turn    in  pulse: reload TURN_SECS and start counting
//  enable       in  1 = count, 0 = pause (lossless)
//  auto_restart in  reload and keep running after expiry (sampled at expiry)
//  sec_tick     out one-cycle pulse per counted second
//  secs_left    out seconds remaining in the current turn
//  warn         out low-time level: running and 0 < secs_left <= WARN_SECS
//  expired      out one-cycle pulse when the allowance runs out
//  running      out high while in RUN
module turn_countdown_timer
    import mastermind_timer_pkg::*;
#(
    parameter int CLK_HZ    = DEF_CLK_HZ,
    parameter int TURN_SECS = DEF_TURN_SECS,
    parameter int WARN_SECS = 10,
    parameter int SEC_W     = 7
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             next_turn,
    input  logic             enable,
    input  logic             auto_restart,
    output logic             sec_tick,
    output logic [SEC_W-1:0] secs_left,
    output logic             warn,
    output logic             expired,
    output logic             running
);

    if (TURN_SECS >= (2 ** SEC_W)) begin : g_bad_turn
        $error("TURN_SECS does not fit in SEC_W bits");
    end
    if (WARN_SECS >= TURN_SECS) begin : g_bad_warn
        $error("WARN_SECS must be below TURN_SECS");
    end
    if (CLK_HZ < 2) begin : g_bad_hz
        $error("CLK_HZ must be at least 2");
    end

    localparam logic [SEC_W-1:0] TURN_V = SEC_W'(TURN_SECS);
    localparam logic [SEC_W-1:0] WARN_V = SEC_W'(WARN_SECS);

    timer_state_t state;
    logic         wrap;

    // Prescaler only runs in RUN; a new turn restarts the partial second.
    sec_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_presc (
        .clk    (clk),
        .resetn (resetn),
        .clr    (next_turn || (state != ST_RUN)),
        .en     (enable && (state == ST_RUN)),
        .tick   (sec_tick),
        .wrap   (wrap)
    );

    // warn is written alongside every secs_left update so both come out of
    // the same edge; TURN_SECS is always above the warn threshold.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            secs_left <= TURN_V;
            running   <= 1'b0;
            warn      <= 1'b0;
            expired   <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (next_turn) begin
                state     <= ST_RUN;
                secs_left <= TURN_V;
                running   <= 1'b1;
                warn      <= 1'b0;
            end else if (state == ST_RUN && wrap) begin
                if (secs_left > SEC_W'(1)) begin
                    secs_left <= secs_left - SEC_W'(1);
                    warn      <= (secs_left - SEC_W'(1)) <= WARN_V;
                end else begin
                    expired <= 1'b1;
                    warn    <= 1'b0;
                    if (auto_restart) begin
                        secs_left <= TURN_V;
                    end else begin
                        state     <= ST_DONE;
                        secs_left <= '0;
                        running   <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
